// File: rtl/regfile_pkg.sv
// Shared widths, opcodes and pipeline-stage records for the register-file controller.
package regfile_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   typedef logic [2:0]        op_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam op_t OP_NOP = 3'd0;
   localparam op_t OP_ADD = 3'd1;
   localparam op_t OP_SUB = 3'd2;
   localparam op_t OP_AND = 3'd3;
   localparam op_t OP_OR  = 3'd4;
   localparam op_t OP_XOR = 3'd5;
   localparam op_t OP_LDI = 3'd6;
   localparam op_t OP_MOV = 3'd7;

   typedef struct packed {
      logic  vld;
      op_t   op;
      addr_t dst;
      data_t a;
      data_t b;
      data_t imm;
   } ex_t;

   typedef struct packed {
      logic  vld;
      logic  wr;
      addr_t dst;
      data_t dat;
   } wb_t;

   function automatic logic writes_back(input op_t op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Command, register-file and result signals of the controller; slave = controller side.
interface regfile_ctrl_if;
   import regfile_pkg::*;

   logic  cmdValid;
   logic  cmdReady;
   op_t   cmdOp;
   addr_t cmdDst;
   addr_t cmdSrcA;
   addr_t cmdSrcB;
   data_t cmdImm;
   logic  hold;

   addr_t readAddrA;
   addr_t readAddrB;
   data_t readDataA;
   data_t readDataB;

   logic  writeEnable;
   addr_t writeAddr;
   data_t writeData;

   logic  resValid;
   data_t resData;

   modport slave (
      input  cmdValid, cmdOp, cmdDst, cmdSrcA, cmdSrcB, cmdImm, hold,
      input  readDataA, readDataB,
      output cmdReady, readAddrA, readAddrB,
      output writeEnable, writeAddr, writeData, resValid, resData
   );

   modport master (
      output cmdValid, cmdOp, cmdDst, cmdSrcA, cmdSrcB, cmdImm, hold,
      output readDataA, readDataB,
      input  cmdReady, readAddrA, readAddrB,
      input  writeEnable, writeAddr, writeData, resValid, resData
   );

endinterface

// File: rtl/regfile_alu.sv
// Combinational ALU: op/a/b/imm -> result, zero latency, arithmetic modulo 2^DATA_W.
module regfile_alu
   import regfile_pkg::*;
(
   input  op_t   op,
   input  data_t a,
   input  data_t b,
   input  data_t imm,
   output data_t result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_LDI:  result = imm;
         OP_MOV:  result = a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/regfile_ctrl.sv
// ACC -> EX -> WB pipeline in front of a 2R/1W register file; write 2 cycles after accept.
// Only back-pressure is hold, which freezes EX/WB and suppresses the write while forwarding stays live.
module regfile_ctrl (
   input  logic           CLK,
   input  logic           nRST,
   regfile_ctrl_if.slave  bus
);
   import regfile_pkg::*;

   ex_t   ex_q;
   wb_t   wb_q;
   data_t ex_res;
   data_t opnd_a;
   data_t opnd_b;
   logic  advance;

   assign advance       = !bus.hold;
   assign bus.cmdReady  = advance;
   assign bus.readAddrA = bus.cmdSrcA;
   assign bus.readAddrB = bus.cmdSrcB;

   regfile_alu u_alu (
      .op     (ex_q.op),
      .a      (ex_q.a),
      .b      (ex_q.b),
      .imm    (ex_q.imm),
      .result (ex_res)
   );

   // Youngest producer wins: EX result, then the pending WB write, then the file itself.
   function automatic data_t fwd(input addr_t src, input data_t rf_dat,
                                 input ex_t ex, input data_t ex_dat, input wb_t wb);
      data_t v;
      if (ex.vld && writes_back(ex.op) && ex.dst == src)
         v = ex_dat;
      else if (wb.vld && wb.wr && wb.dst == src)
         v = wb.dat;
      else
         v = rf_dat;
      return v;
   endfunction

   always_comb begin
      opnd_a = fwd(bus.cmdSrcA, bus.readDataA, ex_q, ex_res, wb_q);
      opnd_b = fwd(bus.cmdSrcB, bus.readDataB, ex_q, ex_res, wb_q);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ex_q <= '0;
         wb_q <= '0;
      end else if (advance) begin
         ex_q.vld <= bus.cmdValid;
         if (bus.cmdValid) begin
            ex_q.op  <= bus.cmdOp;
            ex_q.dst <= bus.cmdDst;
            ex_q.a   <= opnd_a;
            ex_q.b   <= opnd_b;
            ex_q.imm <= bus.cmdImm;
         end
         wb_q.vld <= ex_q.vld;
         wb_q.wr  <= ex_q.vld && writes_back(ex_q.op);
         // Bubbles leave the last address/data on the write port untouched.
         if (ex_q.vld) begin
            wb_q.dst <= ex_q.dst;
            wb_q.dat <= ex_res;
         end
      end
   end

   assign bus.writeEnable = wb_q.vld && wb_q.wr && advance;
   assign bus.writeAddr   = wb_q.dst;
   assign bus.writeData   = wb_q.dat;
   assign bus.resValid    = bus.writeEnable;
   assign bus.resData     = wb_q.dat;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomised scoreboard bench for regfile_ctrl with a behavioural register file.
module tb_regfile_ctrl;
   import regfile_pkg::*;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      int          acc_cyc;
      int          hold_snap;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_ctrl_if bus();

   regfile_ctrl dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus)
   );

   logic [15:0] rf [16] = '{default: 16'h0};
   assign bus.readDataA = rf[bus.readAddrA];
   assign bus.readDataB = rf[bus.readAddrB];
   always @(posedge clk) if (bus.writeEnable) rf[bus.writeAddr] <= bus.writeData;

   int cyc = 0;
   int hold_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.hold) hold_cnt <= hold_cnt + 1;
   end

   exp_t        sbq[$];
   logic [15:0] model_rf [16] = '{default: 16'h0};
   logic [15:0] committed_rf [16] = '{default: 16'h0};
   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [15:0] ref_alu(input int op, input int a, input int b, input int imm);
      int r;
      case (op)
         1: r = (a + b) % 65536;
         2: r = (a - b + 65536) % 65536;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = imm;
         7: r = a;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   // Scoreboard monitor: every write must match the oldest outstanding command.
   always @(negedge clk) begin
      exp_t e;
      if (bus.writeEnable || bus.resValid) begin
         if (sbq.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("wr_addr", 32'(bus.writeAddr), 32'(e.addr));
            check("wr_data", 32'(bus.writeData), 32'(e.data));
            check("res_data", 32'(bus.resData), 32'(e.data));
            check("res_we_pair", {30'd0, bus.resValid, bus.writeEnable}, 32'd3);
            check("wr_latency", cyc - e.acc_cyc, 1 + hold_cnt - e.hold_snap);
            committed_rf[e.addr] = e.data;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cmdValid = 1'b0;
         bus.hold = 1'b0;
         step();
      end
   endtask

   task automatic issue(input int op, input int dst, input int sa, input int sb, input int imm);
      logic [15:0] r;
      exp_t e;
      bus.hold     = 1'b0;
      bus.cmdValid = 1'b1;
      bus.cmdOp    = op[2:0];
      bus.cmdDst   = dst[3:0];
      bus.cmdSrcA  = sa[3:0];
      bus.cmdSrcB  = sb[3:0];
      bus.cmdImm   = imm[15:0];
      r = ref_alu(op, int'(model_rf[sa]), int'(model_rf[sb]), imm & 32'hFFFF);
      if (op != 0) begin
         model_rf[dst] = r;
         e.addr = dst[3:0];
         e.data = r;
         e.acc_cyc = cyc + 1;
         e.hold_snap = hold_cnt;
         sbq.push_back(e);
      end
      step();
      bus.cmdValid = 1'b0;
   endtask

   task automatic hold_cycle();
      bus.hold     = 1'b1;
      bus.cmdValid = 1'($urandom % 2);
      bus.cmdOp    = 3'($urandom);
      bus.cmdDst   = 4'($urandom);
      bus.cmdSrcA  = 4'($urandom);
      bus.cmdSrcB  = 4'($urandom);
      bus.cmdImm   = 16'($urandom);
      @(negedge clk);
      check("hold_ready", 32'(bus.cmdReady), 32'd0);
      check("hold_we", 32'(bus.writeEnable), 32'd0);
      check("hold_res_valid", 32'(bus.resValid), 32'd0);
      @(posedge clk);
      #1;
      bus.hold = 1'b0;
      bus.cmdValid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, 32'(bus.writeEnable), 32'd0);
      check({tag, "_waddr"}, 32'(bus.writeAddr), 32'd0);
      check({tag, "_wdata"}, 32'(bus.writeData), 32'd0);
      check({tag, "_res_valid"}, 32'(bus.resValid), 32'd0);
      check({tag, "_res_data"}, 32'(bus.resData), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int drain;
      bus.cmdValid = 1'b0;
      bus.hold     = 1'b0;
      bus.cmdOp    = 3'd0;
      bus.cmdDst   = 4'd0;
      bus.cmdSrcA  = 4'd3;
      bus.cmdSrcB  = 4'd9;
      bus.cmdImm   = 16'd0;
      step();
      step();
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_ready", 32'(bus.cmdReady), 32'd1);
      check("read_addr_a", 32'(bus.readAddrA), 32'd3);
      check("read_addr_b", 32'(bus.readAddrB), 32'd9);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      issue(6, 1, 0, 0, 16'h0008);
      idle(3);
      check("ldi_r1", 32'(rf[1]), 32'h0008);

      issue(6, 1, 0, 0, 5);
      issue(6, 2, 0, 0, 7);
      issue(1, 3, 1, 2, 0);
      idle(3);
      check("add_fwd_r3", 32'(rf[3]), 32'h000C);

      issue(6, 4, 0, 0, 16'hFFFF);
      issue(1, 4, 4, 4, 0);
      issue(6, 5, 0, 0, 0);
      issue(2, 5, 5, 4, 0);
      idle(3);
      check("add_wrap_r4", 32'(rf[4]), 32'hFFFE);
      check("sub_wrap_r5", 32'(rf[5]), 32'h0002);

      issue(6, 7, 0, 0, 16'h1111);
      issue(6, 8, 0, 0, 16'h2222);
      issue(1, 9, 7, 8, 0);
      idle(1);
      for (int i = 0; i < 3; i++) hold_cycle();
      issue(7, 10, 9, 0, 0);
      idle(3);
      check("hold_add_r9", 32'(rf[9]), 32'h3333);
      check("hold_mov_r10", 32'(rf[10]), 32'h3333);

      issue(6, 11, 0, 0, 16'h1234);
      issue(6, 12, 0, 0, 16'h5678);
      rst_n = 1'b0;
      sbq.delete();
      for (int r = 0; r < 16; r++) model_rf[r] = committed_rf[r];
      @(negedge clk);
      check_reset_outputs("midrst");
      step();
      rst_n = 1'b1;
      idle(4);
      check("rst_drop_r11", 32'(rf[11]), 32'h0);
      check("rst_drop_r12", 32'(rf[12]), 32'h0);
      issue(7, 13, 11, 0, 0);
      issue(4, 14, 11, 12, 0);

      issue(6, 1, 0, 0, 3);
      issue(0, 1, 5, 5, 16'hABCD);
      issue(7, 6, 1, 0, 0);
      idle(3);
      check("nop_r1", 32'(rf[1]), 32'h0003);
      check("nop_mov_r6", 32'(rf[6]), 32'h0003);

      for (int i = 0; i < 400; i++) begin
         int sel;
         sel = $urandom % 10;
         if (sel < 7)
            issue($urandom % 8, $urandom % 16, $urandom % 16, $urandom % 16, $urandom % 65536);
         else if (sel == 7)
            idle(1);
         else
            hold_cycle();
      end

      drain = 0;
      while (sbq.size() != 0 && drain < 20) begin
         idle(1);
         drain++;
      end
      idle(2);
      check("drain_empty", sbq.size(), 32'd0);
      for (int r = 0; r < 16; r++) begin
         check($sformatf("final_rf_r%0d", r), 32'(rf[r]), 32'(model_rf[r]));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
